// File: rtl/vend_pay_arbiter_pkg.sv
// vend_pkg: shared vending constants and the payment arbiter state encoding.
package vend_pkg;
   typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_FIN} state_t;
   localparam int COST_W = 3;
   localparam int CNT_W = 4;
   localparam int DEFAULT_TIMEOUT = 5;
   localparam int MAX_REQ = 4;
   localparam logic [COST_W-1:0] MAX_COST = 3'd7;
endpackage

// File: rtl/vend_pay_arbiter_if.sv
// vend_pay_arbiter_if: front-end request/cost lines and the shared gateway handshake.
interface vend_pay_arbiter_if import vend_pkg::*; #(parameter int NUM_REQ = 2);
   logic [NUM_REQ-1:0] req;
   logic [COST_W*NUM_REQ-1:0] cost_in;
   logic [NUM_REQ-1:0] grant;
   logic [NUM_REQ-1:0] done;
   logic ok;
   logic gw_start;
   logic [COST_W-1:0] gw_cost;
   logic gw_valid;
   logic gw_deny;
   modport slave (input req, cost_in, gw_valid, gw_deny, output grant, done, ok, gw_start, gw_cost);
   modport master (output req, cost_in, gw_valid, gw_deny, input grant, done, ok, gw_start, gw_cost);
endinterface

// File: rtl/vend_pay_arbiter_rr_picker.sv
// rr_picker: combinational round-robin chooser, first set request after ptr with wrap.
module rr_picker #(parameter int N = 2) (
   input  logic [N-1:0] req,
   input  logic [1:0]   ptr,
   output logic         valid,
   output logic [1:0]   idx
);
   // Scan farthest offset first so the nearest hit after ptr is the last write.
   always_comb begin
      valid = 1'b0;
      idx = '0;
      for (int k = N; k >= 1; k--)
         if (((req >> ((int'(ptr) + k) % N)) & N'(1)) != '0) begin
            valid = 1'b1;
            idx = 2'((int'(ptr) + k) % N);
         end
   end
endmodule

// File: rtl/vend_pay_arbiter.sv
// vend_pay_arbiter: round-robin sharing of one payment gateway among vending front ends.
module vend_pay_arbiter import vend_pkg::*; #(
   parameter int NUM_REQ = 2,
   parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
   input logic clk,
   input logic reset,
   vend_pay_arbiter_if.slave bus
);
   state_t state, nxt;
   logic [CNT_W-1:0] cnt;
   logic res;
   logic [1:0] owner, ptr, pick;
   logic [COST_W-1:0] cost;
   logic any;
   logic [MAX_REQ-1:0] oh;
   rr_picker #(.N(NUM_REQ)) u_pick (.req(bus.req), .ptr(ptr), .valid(any), .idx(pick));
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state <= S_IDLE;
         cnt <= '0;
         res <= 1'b0;
         owner <= '0;
         cost <= '0;
         ptr <= 2'(NUM_REQ - 1);
      end else begin
         state <= nxt;
         if (state == S_IDLE && any) begin
            owner <= pick;
            cost <= bus.cost_in[COST_W*pick +: COST_W];
         end
         cnt <= state == S_START ? '0 : state == S_WAIT ? cnt + 1'b1 : cnt;
         // Only the value on the exiting WAIT cycle survives into FIN; deny beats valid.
         if (state == S_WAIT) res <= bus.gw_valid && !bus.gw_deny;
         if (state == S_FIN) ptr <= owner;
      end
   always_comb begin
      nxt = state;
      if (state == S_IDLE && any) nxt = S_START;
      if (state == S_START) nxt = S_WAIT;
      if (state == S_WAIT && (bus.gw_deny || bus.gw_valid || cnt == CNT_W'(TIMEOUT - 1))) nxt = S_FIN;
      if (state == S_FIN) nxt = S_IDLE;
      oh = MAX_REQ'(1) << owner;
      bus.grant = state != S_IDLE ? oh[NUM_REQ-1:0] : '0;
      bus.done = state == S_FIN ? oh[NUM_REQ-1:0] : '0;
      bus.ok = state == S_FIN && res;
      bus.gw_start = state == S_START;
      bus.gw_cost = state != S_IDLE ? cost : '0;
   end
endmodule

// File: tb/tb_vend_pay_arbiter.sv
// tb_vend_pay_arbiter: vector table, randomized transactions against a timeline model, reset abort.
module tb_vend_pay_arbiter;
   import vend_pkg::*;
   localparam int N = 2;
   localparam int TO = 5;
   typedef logic [2*N+4:0] obs_t;
   typedef struct {
      logic [N-1:0] req;
      logic [3*N-1:0] cost;
      int k;
      int kind;
      int owner;
      logic [2:0] ecost;
      logic eok;
      int eend;
   } vec_t;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int passed = 0;
   int total = 0;
   int ptr_m = N - 1;
   vec_t tv[10];
   vend_pay_arbiter_if #(.NUM_REQ(N)) bus();
   vend_pay_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;
   function automatic obs_t observe();
      return {bus.grant, bus.done, bus.ok, bus.gw_start, bus.gw_cost};
   endfunction
   function automatic obs_t mk(input logic [N-1:0] g, input logic [N-1:0] d, input logic o, input logic s, input logic [2:0] c);
      return {g, d, o, s, c};
   endfunction
   task automatic chk(input string name, input obs_t act, input obs_t exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %b want %b (grant,done,ok,start,cost)", name, act, exp);
   endtask
   function automatic int model_pick(input logic [N-1:0] r);
      for (int off = 1; off <= N; off++)
         if (((r >> ((ptr_m + off) % N)) & N'(1)) != '0) return (ptr_m + off) % N;
      return -1;
   endfunction
   // k: WAIT cycle (0-based) carrying the gateway response, -1 for none; kind 0 valid, 1 deny, 2 both.
   task automatic run_txn(input string name, input logic [N-1:0] r, input logic [3*N-1:0] cv, input int k,
                          input int kind, input int own, input logic [2:0] ec, input logic eok, input int e);
      logic [N-1:0] oh;
      if (r == '0) begin
         bus.req = '0;
         bus.cost_in = (3*N)'($urandom);
         bus.gw_valid = 1'b1;
         bus.gw_deny = 1'b0;
         @(negedge clk);
         chk({name, "_idle"}, observe(), '0);
         @(posedge clk);
         #1;
         return;
      end
      oh = N'(1) << own;
      for (int c = 0; c <= e; c++) begin
         bus.req = c == 0 ? r : N'($urandom);
         bus.cost_in = c == 0 ? cv : (3*N)'($urandom);
         if (c >= 2 && c < e) begin
            bus.gw_valid = c == 2 + k && kind != 1;
            bus.gw_deny = c == 2 + k && kind != 0;
         end else begin
            bus.gw_valid = 1'($urandom);
            bus.gw_deny = 1'($urandom);
         end
         @(negedge clk);
         chk($sformatf("%s_c%0d", name, c), observe(),
             mk(c >= 1 ? oh : '0, c == e ? oh : '0, c == e && eok, c == 1, c >= 1 ? ec : 3'd0));
         @(posedge clk);
         #1;
      end
      ptr_m = own;
   endtask
   initial begin
      tv[0] = '{2'b01, 6'o02, 0, 0, 0, 3'd2, 1'b1, 3};
      tv[1] = '{2'b11, 6'o34, 0, 0, 1, 3'd3, 1'b1, 3};
      tv[2] = '{2'b11, 6'o71, 0, 0, 0, 3'd1, 1'b1, 3};
      tv[3] = '{2'b11, 6'o60, 0, 0, 1, 3'd6, 1'b1, 3};
      tv[4] = '{2'b10, 6'o52, -1, 0, 1, 3'd5, 1'b0, 7};
      tv[5] = '{2'b11, 6'o17, 1, 2, 0, 3'd7, 1'b0, 4};
      tv[6] = '{2'b11, 6'o40, 4, 0, 1, 3'd4, 1'b1, 7};
      tv[7] = '{2'b01, 6'o03, 2, 1, 0, 3'd3, 1'b0, 5};
      tv[8] = '{2'b00, 6'o00, -1, 0, 0, 3'd0, 1'b0, 0};
      tv[9] = '{2'b10, 6'o70, 3, 0, 1, 3'd7, 1'b1, 6};
      bus.req = '0;
      bus.cost_in = '0;
      bus.gw_valid = 1'b0;
      bus.gw_deny = 1'b0;
      #1;
      chk("reset_state", observe(), '0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      for (int i = 0; i < 10; i++)
         run_txn($sformatf("vec%0d", i), tv[i].req, tv[i].cost, tv[i].k, tv[i].kind,
                 tv[i].owner, tv[i].ecost, tv[i].eok, tv[i].eend);
      for (int i = 0; i < 60; i++) begin
         logic [N-1:0] r;
         logic [3*N-1:0] cv;
         int k, kind, own;
         logic hit;
         r = N'($urandom);
         cv = (3*N)'($urandom);
         k = int'($urandom_range(TO + 1)) - 1;
         kind = int'($urandom_range(2));
         own = model_pick(r);
         hit = k >= 0 && k < TO;
         run_txn($sformatf("rnd%0d", i), r, cv, k, kind, own < 0 ? 0 : own, 3'(cv >> (3 * (own < 0 ? 0 : own))),
                 hit && kind == 0, hit ? 3 + k : TO + 2);
      end
      begin
         logic [N-1:0] oh;
         oh = N'(1) << model_pick(2'b11);
         bus.req = 2'b11;
         bus.cost_in = 6'o35;
         bus.gw_valid = 1'b0;
         bus.gw_deny = 1'b0;
         for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            @(posedge clk);
            #1;
         end
         chk("rst_pre", observe(), mk(oh, '0, 1'b0, 1'b0, model_pick(2'b11) == 0 ? 3'd5 : 3'd3));
         reset = 1'b1;
         #1;
         chk("rst_async", observe(), '0);
         @(negedge clk);
         chk("rst_hold", observe(), '0);
         @(posedge clk);
         #1;
         reset = 1'b0;
         ptr_m = N - 1;
         run_txn("rst_after", 2'b11, 6'o35, 0, 0, 0, 3'd5, 1'b1, 3);
      end
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
